// File: rtl/simple_dmem_arb.sv
// simple_dmem_arb: shares one single-port data memory between the CPU
// (port 0, fixed priority) and a debug/loader master (port 1, anti-starvation).
module simple_dmem_arb #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          dmem_wren,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_din,
    input  logic [DW-1:0] dmem_dout
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0]    wait_cnt;
    logic [3:0]    wait_nxt;
    logic          boost;
    logic          boost_nxt;
    logic          rd_pend;
    logic          rd_port;
    logic          any_gnt;
    logic          gnt_we;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    // Port 0 wins ties unless port 1 has been boosted; nothing is granted in reset
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                p0_gnt = !boost;
                p1_gnt = boost;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    // Steer the winner onto the memory; idle cycles keep the last address/data
    always_comb begin
        any_gnt   = p0_gnt | p1_gnt;
        gnt_we    = 1'b0;
        dmem_addr = addr_q;
        dmem_din  = din_q;
        if (p1_gnt) begin
            gnt_we    = p1_we;
            dmem_addr = p1_addr;
            dmem_din  = p1_wdata;
        end else if (p0_gnt) begin
            gnt_we    = p0_we;
            dmem_addr = p0_addr;
            dmem_din  = p0_wdata;
        end
        dmem_wren = gnt_we;
    end

    // Count consecutive port 1 denials; boost takes effect the cycle after saturation
    always_comb begin
        wait_nxt = 4'd0;
        if (p1_req && !p1_gnt) begin
            if (wait_cnt >= WAIT_MAX) begin
                wait_nxt = WAIT_MAX;
            end else begin
                wait_nxt = wait_cnt + 4'd1;
            end
        end
        boost_nxt = !p1_gnt && (boost || (wait_nxt == WAIT_MAX));
    end

    // Arbitration state and the held memory address/data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
            boost    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            boost    <= boost_nxt;
            if (any_gnt) begin
                addr_q <= dmem_addr;
                din_q  <= dmem_din;
            end
        end
    end

    // Remember which port owns the read whose data the memory returns next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            rd_pend <= any_gnt && !gnt_we;
            rd_port <= p1_gnt;
        end
    end

    assign p0_rvalid = rd_pend && !rd_port;
    assign p1_rvalid = rd_pend && rd_port;

    // Each port's read data holds between its own valid strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (p0_rvalid) begin
                rdata0_q <= dmem_dout;
            end
            if (p1_rvalid) begin
                rdata1_q <= dmem_dout;
            end
        end
    end

    assign p0_rdata = p0_rvalid ? dmem_dout : rdata0_q;
    assign p1_rdata = p1_rvalid ? dmem_dout : rdata1_q;

endmodule

// File: tb/tb_simple_dmem_arb.sv
// tb_simple_dmem_arb: directed and random traffic against simple_dmem_arb
// with a behavioural memory, an arbitration model and a read scoreboard.
module tb_simple_dmem_arb;

    localparam int MAX_WAIT = 4;

    logic       clk;
    logic       reset;
    logic       p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [7:0] p0_addr, p0_wdata, p0_rdata;
    logic       p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [7:0] p1_addr, p1_wdata, p1_rdata;
    logic       dmem_wren;
    logic [7:0] dmem_addr, dmem_din, dmem_dout;

    int checks;
    int errors;
    logic en;

    // monitor-owned model state
    logic [7:0] mmem [256];
    logic [8:0] sbq [$];
    logic       mboost;
    int         mwait;
    int         wait_obs;
    logic [7:0] m_addr, m_din, m_rd0, m_rd1;
    logic       k0, k1;
    logic       last_g0, last_g1;

    simple_dmem_arb #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata),
        .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // registered single-port memory
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (dmem_wren) mem[dmem_addr] <= dmem_din;
        dmem_dout <= mem[dmem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r0, input logic w0,
                       input logic [7:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1,
                       input logic [7:0] a1, input logic [7:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pre(input int i);
        if (i == 3) return 8'h11;
        if (i == 4) return 8'h22;
        return 8'(i * 13 + 7);
    endfunction

    // per-cycle monitor: model arbitration, memory steering, read scoreboard
    initial begin
        logic eg0, eg1, ewe;
        logic [7:0] ea, ed;
        logic [8:0] it;
        int wn;
        mboost = 1'b0; mwait = 0; wait_obs = 0;
        m_addr = 8'h00; m_din = 8'h00; m_rd0 = 8'h00; m_rd1 = 8'h00;
        k0 = 1'b0; k1 = 1'b0; last_g0 = 1'b0; last_g1 = 1'b0;
        forever begin
            @(negedge clk);
            if (en && reset) begin
                chk("rst_g0", 32'(p0_gnt), 0);
                chk("rst_g1", 32'(p1_gnt), 0);
                chk("rst_rv0", 32'(p0_rvalid), 0);
                chk("rst_rv1", 32'(p1_rvalid), 0);
                chk("rst_wren", 32'(dmem_wren), 0);
                chk("rst_addr", 32'(dmem_addr), 0);
                chk("rst_din", 32'(dmem_din), 0);
                sbq.delete();
                mboost = 1'b0; mwait = 0; wait_obs = 0;
                m_addr = 8'h00; m_din = 8'h00;
                k0 = 1'b0; k1 = 1'b0;
                last_g0 = 1'b0; last_g1 = 1'b0;
            end else if (en) begin
                eg0 = p0_req && (!p1_req || !mboost);
                eg1 = p1_req && !eg0;
                chk("gnt0", 32'(p0_gnt), 32'(eg0));
                chk("gnt1", 32'(p1_gnt), 32'(eg1));
                ewe = 1'b0; ea = 8'h00; ed = 8'h00;
                if (eg1) begin
                    ewe = p1_we; ea = p1_addr; ed = p1_wdata;
                end else if (eg0) begin
                    ewe = p0_we; ea = p0_addr; ed = p0_wdata;
                end
                if (eg0 || eg1) begin
                    m_addr = ea; m_din = ed;
                end
                chk("wren", 32'(dmem_wren), 32'(ewe));
                chk("addr", 32'(dmem_addr), 32'(m_addr));
                chk("din", 32'(dmem_din), 32'(m_din));
                if (sbq.size() > 0) begin
                    it = sbq.pop_front();
                    chk("rv0", 32'(p0_rvalid), 32'(!it[8]));
                    chk("rv1", 32'(p1_rvalid), 32'(it[8]));
                    if (it[8]) begin
                        m_rd1 = it[7:0]; k1 = 1'b1;
                    end else begin
                        m_rd0 = it[7:0]; k0 = 1'b1;
                    end
                end else begin
                    chk("rv0_idle", 32'(p0_rvalid), 0);
                    chk("rv1_idle", 32'(p1_rvalid), 0);
                end
                if (k0) chk("rdata0", 32'(p0_rdata), 32'(m_rd0));
                if (k1) chk("rdata1", 32'(p1_rdata), 32'(m_rd1));
                if (eg0 || eg1) begin
                    if (ewe) mmem[ea] = ed;
                    else sbq.push_back({eg1, mmem[ea]});
                end
                if (p1_req && !p1_gnt) begin
                    wait_obs++;
                    chk("p1_wait", 32'(wait_obs > MAX_WAIT), 0);
                end else begin
                    wait_obs = 0;
                end
                wn = 0;
                if (p1_req && !eg1) wn = (mwait >= MAX_WAIT) ? MAX_WAIT : mwait + 1;
                mboost = !eg1 && (mboost || (wn == MAX_WAIT));
                mwait = wn;
                last_g0 = p0_gnt;
                last_g1 = p1_gnt;
            end
        end
    end

    initial begin
        logic [9:0] pat;
        checks = 0; errors = 0; en = 1'b0;
        reset = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        #2 reset = 1'b1;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // preload through port 1 alone: granted immediately every cycle
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1, 1, 8'(i), pre(i));

        // p0 write then read of 0x10
        cyc(1, 1, 8'h10, 8'h5A, 0, 0, 0, 0);
        cyc(1, 0, 8'h10, 8'h00, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_rdata", 32'(p0_rdata), 32'h5A);

        // both ports requesting continuously
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 8'h05, 0, 1, 0, 8'h06, 0);
            pat = {pat[8:0], last_g1};
        end
        chk("starve_pat", 32'(pat), 32'(10'b0000100001));
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // back-to-back reads from alternating ports
        cyc(0, 0, 0, 0, 1, 0, 8'h03, 0);
        cyc(1, 0, 8'h04, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_rd1", 32'(p1_rdata), 32'h11);
        chk("t3_rd0", 32'(p0_rdata), 32'h22);

        // reset while a p0 read is in flight and p1 has been waiting
        cyc(1, 0, 8'h02, 0, 1, 0, 8'h03, 0);
        cyc(1, 0, 8'h02, 0, 1, 0, 8'h03, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        p0_we = 1'b1; p0_addr = 8'h07; p0_wdata = 8'h99;
        #1;
        chk("rst_wait", 32'(dut.wait_cnt), 0);
        chk("rst_boost", 32'(dut.boost), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cyc(1, 1, 8'h07, 8'h99, 1, 0, 8'h03, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h07, 0, 1, 0, 8'h03, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_rd0", 32'(p0_rdata), 32'h99);
        chk("t5_rd1", 32'(p1_rdata), 32'h11);

        // random traffic obeying the hold-until-grant rule
        for (int i = 0; i < 2000; i++) begin
            if (!p0_req || last_g0) begin
                p0_req = ($urandom_range(0, 9) < 7);
                p0_we = 1'($urandom_range(0, 1));
                p0_addr = 8'($urandom_range(0, 15));
                p0_wdata = 8'($urandom);
            end
            if (!p1_req || last_g1) begin
                p1_req = ($urandom_range(0, 9) < 5);
                p1_we = 1'($urandom_range(0, 1));
                p1_addr = 8'($urandom_range(0, 15));
                p1_wdata = 8'($urandom);
            end
            @(posedge clk);
            #1;
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
